// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: register offsets within the MMIO window,
// EVENT word field positions and the registered read-source select encoding.
package mmio_pkg;

   // These offsets are added to N_OUT, the output registers occupy 0..N_OUT-1
   localparam int OFS_STATUS = 0;
   localparam int OFS_EVENT  = 1;
   localparam int OFS_LEVEL  = 2;

   localparam int EV_VALID   = 31;
   localparam int EV_OVF     = 30;
   localparam int EV_CNT_LSB = 16;
   localparam int EV_CNT_W   = 8;
   localparam int EV_IDX_W   = 4;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_OUT,
      SEL_STATUS,
      SEL_EVENT,
      SEL_LEVEL,
      SEL_ZERO
   } sel_t;

endpackage

// File: rtl/mmio_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that only
// lets the debounced level follow the input after DEBOUNCE_CYC disagreeing cycles.
module mmio_debounce #(
   parameter int DEBOUNCE_CYC = 1000000
)(
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Counter restarts on any agreeing sample, so only an unbroken run flips the level
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/mmio_hub.sv
// Decodes dmem accesses to RAM or an MMIO window (output regs, status, event, levels).
// Define MMIO_EVENT_FIFO_EN to build the button event FIFO; otherwise EVENT mirrors the levels.
module mmio_hub
   import mmio_pkg::*;
#(
   parameter int                ADDR_W       = 12,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] MMIO_BASE    = ADDR_W'(12'hF00),
   parameter int                N_OUT        = 4,
   parameter int                N_BTN        = 5,
   parameter int                FIFO_DEPTH   = 8,
   parameter int                DEBOUNCE_CYC = 1000000
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wren,
   input  logic                    rden,
   input  logic [ADDR_W-1:0]       address_dmem,
   input  logic [DATA_W-1:0]       data,
   output logic [DATA_W-1:0]       q_dmem,
   output logic                    ram_wEn,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_dataIn,
   input  logic [DATA_W-1:0]       ram_dataOut,
   input  logic [N_BTN-1:0]        btn_raw,
   input  logic [DATA_W-1:0]       status_in,
   output logic [N_OUT*DATA_W-1:0] out_regs
);

   logic [ADDR_W-1:0] offset;
   logic              is_mmio;
   sel_t              sel;
   sel_t              sel_q;
   logic [DATA_W-1:0] out_q [N_OUT];
   logic [DATA_W-1:0] mmio_d;
   logic [DATA_W-1:0] mmio_q;
   logic [DATA_W-1:0] ev_word;
   logic [N_BTN-1:0]  level;
   logic              ev_read;

   assign offset     = address_dmem - MMIO_BASE;
   assign is_mmio    = address_dmem >= MMIO_BASE;
   assign ram_addr   = address_dmem;
   assign ram_dataIn = data;
   assign ram_wEn    = wren & ~is_mmio;
   assign ev_read    = rden && (sel == SEL_EVENT);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      mmio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
         .clock (clock),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (level[i])
      );
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_regs[k*DATA_W +: DATA_W] = out_q[k];
   end

   always_comb begin
      sel = SEL_RAM;
      if (is_mmio) begin
         if (offset < ADDR_W'(N_OUT))                        sel = SEL_OUT;
         else if (offset == ADDR_W'(N_OUT + OFS_STATUS))     sel = SEL_STATUS;
         else if (offset == ADDR_W'(N_OUT + OFS_EVENT))      sel = SEL_EVENT;
         else if (offset == ADDR_W'(N_OUT + OFS_LEVEL))      sel = SEL_LEVEL;
         else                                                sel = SEL_ZERO;
      end
   end

   always_comb begin
      mmio_d = '0;
      case (sel)
         SEL_OUT: begin
            for (int k = 0; k < N_OUT; k++)
               if (offset == ADDR_W'(k)) mmio_d = out_q[k];
         end
         SEL_STATUS: mmio_d = status_in;
         SEL_EVENT:  mmio_d = ev_word;
         SEL_LEVEL:  mmio_d = DATA_W'(level);
         default:    mmio_d = '0;
      endcase
   end

   // MMIO read data is captured in the address cycle so it lines up with the synchronous RAM
   always_ff @(posedge clock) begin
      if (reset) begin
         sel_q  <= SEL_ZERO;
         mmio_q <= '0;
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      end else begin
         if (rden) begin
            sel_q  <= sel;
            mmio_q <= mmio_d;
         end
         if (wren && sel == SEL_OUT) begin
            for (int k = 0; k < N_OUT; k++)
               if (offset == ADDR_W'(k)) out_q[k] <= data;
         end
      end
   end

   assign q_dmem = (sel_q == SEL_RAM) ? ram_dataOut : mmio_q;

`ifdef MMIO_EVENT_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [EV_IDX_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [N_BTN-1:0]    level_q;
   logic [N_BTN-1:0]    pending;
   logic [N_BTN-1:0]    rise;
   logic [N_BTN-1:0]    clear;
   logic [EV_IDX_W-1:0] push_idx;
   logic                push;
   logic                pop;
   logic                ovf;

   assign rise = level & ~level_q;
   assign pop  = ev_read && (count != '0);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
   always_comb begin
      push_idx = '0;
      push     = 1'b0;
      clear    = '0;
      for (int i = N_BTN - 1; i >= 0; i--)
         if (pending[i]) push_idx = EV_IDX_W'(i);
      if ((pending != '0) && ((count != CNT_W'(FIFO_DEPTH)) || pop)) begin
         push  = 1'b1;
         clear = N_BTN'(1) << push_idx;
      end
   end

   always_comb begin
      ev_word                               = '0;
      ev_word[EV_VALID]                     = (count != '0);
      ev_word[EV_OVF]                       = ovf;
      ev_word[EV_CNT_LSB +: EV_CNT_W]       = EV_CNT_W'(count);
      if (count != '0) ev_word[EV_IDX_W-1:0] = fifo_mem[rd_ptr];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         level_q <= '0;
         pending <= '0;
         ovf     <= 1'b0;
      end else begin
         level_q <= level;
         pending <= (pending & ~clear) | rise;
         ovf     <= (ovf & ~ev_read) | (|(rise & pending & ~clear));
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count   <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= push_idx;
   end
`else
   always_comb begin
      ev_word                = '0;
      ev_word[EV_VALID]      = |level;
      ev_word[N_BTN-1:0]     = level;
   end
`endif

endmodule
